arbitro_transacciones_i2c: RTL

//  Shares one I2C transaction generator between two CPU-side requesters (ports A and B).

---
 rtl/arbitro_transacciones_i2c.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/arbitro_transacciones_i2c.sv
// Two-port arbiter in front of a single I2C transaction generator.
// A request from port A or B is latched, launched on the generator, and the
// generator's completion (or a local timeout) is reported back to the winner only.
// Ties are resolved round-robin, starting with port A after reset.

module arbitro_transacciones_i2c #(
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned TO_W        = 13
) (
  input  logic        clk_arbitro,
  input  logic        rst_arbitro_n,

  // Requester A
  input  logic        REQ_A,
  input  logic        RNW_A,
  input  logic [6:0]  ADDR_A,
  input  logic [15:0] WDAT_A,
  output logic        GNT_A,
  output logic        DONE_A,
  output logic [15:0] RDAT_A,
  output logic [1:0]  ERR_A,

  // Requester B
  input  logic        REQ_B,
  input  logic        RNW_B,
  input  logic [6:0]  ADDR_B,
  input  logic [15:0] WDAT_B,
  output logic        GNT_B,
  output logic        DONE_B,
  output logic [15:0] RDAT_B,
  output logic [1:0]  ERR_B,

  // Generator side
  input  logic        GEN_BUSY,
  input  logic        GEN_DONE,
  input  logic        GEN_ACK_ERR,
  input  logic [15:0] GEN_RD_DATA,
  output logic        GEN_START,
  output logic        GEN_RNW,
  output logic [6:0]  GEN_ADDR,
  output logic [15:0] GEN_WR_DATA,
  output logic        GEN_ABORT
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLaunch = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StFin    = 2'd3;

  // Last counter value of the wait window; reaching it without GEN_DONE aborts.
  localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrTimeout = 2'b10;

  // State
  logic [1:0]      r_state;
  logic            r_winner;    // 0 = A, 1 = B
  logic            r_rr_ptr;    // port preferred on the next tie
  logic [TO_W-1:0] r_to_cnt;
  logic            r_gen_rnw;
  logic [6:0]      r_gen_addr;
  logic [15:0]     r_gen_wdat;
  logic            r_abort;
  logic [15:0]     r_rdat_a;
  logic [15:0]     r_rdat_b;
  logic [1:0]      r_err_a;
  logic [1:0]      r_err_b;

  // Decoded controls
  logic [1:0]      w_state_d;
  logic            w_any_req;
  logic            w_launch;
  logic            w_pick_b;
  logic            w_gen_fin;
  logic            w_to_hit;
  logic            w_to_fin;
  logic            w_fin;

  // Request qualification and winner selection in IDLE.
  always_comb begin
    w_any_req = REQ_A | REQ_B;
    w_launch  = (r_state == StIdle) && !GEN_BUSY && w_any_req;
    // On a tie the round-robin pointer decides; otherwise the lone requester wins.
    w_pick_b  = (REQ_A && REQ_B) ? r_rr_ptr : REQ_B;
  end

  // Completion decode in WAIT; a GEN_DONE coinciding with the timeout takes priority.
  always_comb begin
    w_gen_fin = (r_state == StWait) && GEN_DONE;
    w_to_hit  = (r_state == StWait) && (r_to_cnt == ToLast);
    w_to_fin  = w_to_hit && !GEN_DONE;
    w_fin     = (r_state == StFin);
  end

  // Next-state logic of the transaction sequencer.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_launch) begin
          w_state_d = StLaunch;
        end
      end
      StLaunch: begin
        w_state_d = StWait;
      end
      StWait: begin
        if (w_gen_fin || w_to_fin) begin
          w_state_d = StFin;
        end
      end
      StFin: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_arbitro or negedge rst_arbitro_n) begin
    if (!rst_arbitro_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Winner id and round-robin pointer; the pointer flips away from the port just served.
  always_ff @(posedge clk_arbitro or negedge rst_arbitro_n) begin
    if (!rst_arbitro_n) begin
      r_winner <= 1'b0;
      r_rr_ptr <= 1'b0;
    end else begin
      if (w_launch) begin
        r_winner <= w_pick_b;
      end
      if (w_fin) begin
        r_rr_ptr <= ~r_winner;
      end
    end
  end

  // Latch the winner's request fields; later input changes are ignored.
  always_ff @(posedge clk_arbitro or negedge rst_arbitro_n) begin
    if (!rst_arbitro_n) begin
      r_gen_rnw  <= 1'b0;
      r_gen_addr <= 7'd0;
      r_gen_wdat <= 16'd0;
    end else if (w_launch) begin
      if (w_pick_b) begin
        r_gen_rnw  <= RNW_B;
        r_gen_addr <= ADDR_B;
        r_gen_wdat <= WDAT_B;
      end else begin
        r_gen_rnw  <= RNW_A;
        r_gen_addr <= ADDR_A;
        r_gen_wdat <= WDAT_A;
      end
    end
  end

  // Timeout counter: cleared in LAUNCH, counts every WAIT cycle.
  always_ff @(posedge clk_arbitro or negedge rst_arbitro_n) begin
    if (!rst_arbitro_n) begin
      r_to_cnt <= '0;
    end else if (r_state == StWait) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Abort pulse lands in the FIN cycle that follows a timeout.
  always_ff @(posedge clk_arbitro or negedge rst_arbitro_n) begin
    if (!rst_arbitro_n) begin
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_to_fin;
    end
  end

  // Per-port status: only the winner's ERR/RDAT change; RDAT only on a clean read.
  always_ff @(posedge clk_arbitro or negedge rst_arbitro_n) begin
    if (!rst_arbitro_n) begin
      r_rdat_a <= 16'd0;
      r_rdat_b <= 16'd0;
      r_err_a  <= ErrOk;
      r_err_b  <= ErrOk;
    end else if (w_gen_fin) begin
      if (r_winner) begin
        r_err_b <= {1'b0, GEN_ACK_ERR};
        if (r_gen_rnw && !GEN_ACK_ERR) begin
          r_rdat_b <= GEN_RD_DATA;
        end
      end else begin
        r_err_a <= {1'b0, GEN_ACK_ERR};
        if (r_gen_rnw && !GEN_ACK_ERR) begin
          r_rdat_a <= GEN_RD_DATA;
        end
      end
    end else if (w_to_fin) begin
      if (r_winner) begin
        r_err_b <= ErrTimeout;
      end else begin
        r_err_a <= ErrTimeout;
      end
    end
  end

  // Outputs are pure decodes of registered state, so reset clears them at once.
  always_comb begin
    GEN_START   = (r_state == StLaunch);
    GEN_RNW     = r_gen_rnw;
    GEN_ADDR    = r_gen_addr;
    GEN_WR_DATA = r_gen_wdat;
    GEN_ABORT   = r_abort;
    GNT_A       = (r_state != StIdle) && !r_winner;
    GNT_B       = (r_state != StIdle) &&  r_winner;
    DONE_A      = w_fin && !r_winner;
    DONE_B      = w_fin &&  r_winner;
    RDAT_A      = r_rdat_a;
    RDAT_B      = r_rdat_b;
    ERR_A       = r_err_a;
    ERR_B       = r_err_b;
  end

endmodule
